pf_pool_sequencer: RTL and testbench

//  Sequences one pooling pass of the PF compute unit over an image held in a line/frame memory.

---
 rtl/pf_pkg.sv | 37 +++
 rtl/pf_win_addr_gen.sv | 104 ++++++++++
 rtl/pf_pool_sequencer.sv | 149 ++++++++++++++
 tb/tb_pf_pool_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pf_pkg.sv
// Shared definitions for the PF pooling sequencer: op codes, cntrl encodings,
// window-size limits, FSM state type and the configuration legality check.
package pf_pkg;

    // Compute-unit operation codes (2'b11 is not a legal op)
    localparam logic [1:0] AVG = 2'b00;
    localparam logic [1:0] MIN = 2'b01;
    localparam logic [1:0] MAX = 2'b10;

    // cntrl encodings toward the compute unit
    localparam logic CYCLE       = 1'b0;
    localparam logic START_CYCLE = 1'b1;

    // Legal square window sizes
    localparam logic [2:0] K_MIN = 3'd2;
    localparam logic [2:0] K_MAX = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } pf_seq_state_t;

    // High when a frame configuration cannot be sequenced
    function automatic logic cfg_illegal(input logic [2:0]  k,
                                         input logic [1:0]  op,
                                         input logic [31:0] w,
                                         input logic [31:0] h);
        logic [31:0] k_w;
        k_w = {29'd0, k};
        cfg_illegal = (k < K_MIN) || (k > K_MAX) || (w < k_w) || (h < k_w) ||
                      (op == 2'b11);
    endfunction

endpackage

// File: rtl/pf_win_addr_gen.sv
// Window-raster address generator. Walks windows row-major and pixels inside
// each window row-major using only counters and adders. init (one cycle)
// loads the base address; every adv cycle steps to the next pixel address.
module pf_win_addr_gen
    import pf_pkg::*;
#(
    parameter int LIN_WIDTH = 10,
    parameter int ADDR_W    = 2 * LIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 init,
    input  logic                 adv,
    input  logic [ADDR_W-1:0]    base,
    input  logic [LIN_WIDTH-1:0] img_w,
    input  logic [LIN_WIDTH-1:0] img_h,
    input  logic [2:0]           win_k,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 first_px,
    output logic                 last_rd
);
    // Column/row positions need headroom for "position + 2K" fit tests
    localparam int CW = LIN_WIDTH + 2;

    logic [2:0]        kx_r, ky_r, kx_n, ky_n;
    logic [CW-1:0]     col_r, col_n, yrow_r, yrow_n, k_s;
    logic [ADDR_W-1:0] row_r, row_n, wrow_r, wrow_n, addr_r, addr_n, w_s;
    logic              kx_last_s, ky_last_s, wx_last_s, wy_last_s;

    assign k_s       = CW'(win_k);
    assign w_s       = ADDR_W'(img_w);
    assign kx_last_s = (kx_r == (win_k - 3'd1));
    assign ky_last_s = (ky_r == (win_k - 3'd1));
    // Last window in a row/column when another full window would not fit
    assign wx_last_s = ((col_r + k_s + k_s) > CW'(img_w));
    assign wy_last_s = ((yrow_r + k_s + k_s) > CW'(img_h));

    assign first_px  = (kx_r == 3'd0) && (ky_r == 3'd0);
    assign last_rd   = kx_last_s && ky_last_s && wx_last_s && wy_last_s;
    assign rd_addr   = addr_r;

    // Next-pixel stepping: row_r is the image-row start, wrow_r the start of the window row
    always_comb begin
        kx_n   = kx_r;
        ky_n   = ky_r;
        col_n  = col_r;
        yrow_n = yrow_r;
        row_n  = row_r;
        wrow_n = wrow_r;
        if (init) begin
            kx_n   = 3'd0;
            ky_n   = 3'd0;
            col_n  = {CW{1'b0}};
            yrow_n = {CW{1'b0}};
            row_n  = base;
            wrow_n = base;
        end else if (adv) begin
            if (!kx_last_s) begin
                kx_n = kx_r + 3'd1;
            end else if (!ky_last_s) begin
                kx_n  = 3'd0;
                ky_n  = ky_r + 3'd1;
                row_n = row_r + w_s;
            end else if (!wx_last_s) begin
                kx_n  = 3'd0;
                ky_n  = 3'd0;
                col_n = col_r + k_s;
                row_n = wrow_r;
            end else begin
                kx_n   = 3'd0;
                ky_n   = 3'd0;
                col_n  = {CW{1'b0}};
                yrow_n = yrow_r + k_s;
                row_n  = row_r + w_s;
                wrow_n = row_r + w_s;
            end
        end else begin
            kx_n = kx_r;
        end
        addr_n = row_n + ADDR_W'(col_n) + ADDR_W'(kx_n);
    end

    // Counter and accumulator registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            kx_r   <= 3'd0;
            ky_r   <= 3'd0;
            col_r  <= {CW{1'b0}};
            yrow_r <= {CW{1'b0}};
            row_r  <= {ADDR_W{1'b0}};
            wrow_r <= {ADDR_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else begin
            kx_r   <= kx_n;
            ky_r   <= ky_n;
            col_r  <= col_n;
            yrow_r <= yrow_n;
            row_r  <= row_n;
            wrow_r <= wrow_n;
            addr_r <= addr_n;
        end
    end

endmodule

// File: rtl/pf_pool_sequencer.sv
// PF pooling-pass sequencer: frame FSM, config latch, 2-stage start-tag/valid
// delay line toward the compute unit. Optional macro PF_ADDR_BASE_EN adds a
// base_addr input (latched in LOAD) added to every read address.
module pf_pool_sequencer
    import pf_pkg::*;
#(
    parameter int LIN_WIDTH = 10,
    parameter int ADDR_W    = 2 * LIN_WIDTH
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [1:0]           op_type_in,
    input  logic [LIN_WIDTH-1:0] img_w,
    input  logic [LIN_WIDTH-1:0] img_h,
    input  logic [2:0]           win_k,
`ifdef PF_ADDR_BASE_EN
    input  logic [ADDR_W-1:0]    base_addr,
`endif
    output logic [ADDR_W-1:0]    rd_addr,
    output logic                 rd_en,
    output logic                 din_valid,
    output logic                 cntrl,
    output logic [1:0]           op_type,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);
    pf_seq_state_t        state_r, state_n;
    logic [1:0]           flush_cnt_r, flush_cnt_n;
    logic [LIN_WIDTH-1:0] img_w_r, img_h_r;
    logic [2:0]           win_k_r;
    logic [1:0]           op_type_r;
    logic                 rd_en_r, din_valid_r, tag_d1_r, cntrl_r;
    logic                 busy_r, done_r, cfg_err_r;
    logic                 init_s, adv_s, tag_s, illegal_s, first_px_s, last_rd_s;
    logic [ADDR_W-1:0]    base_s;

`ifdef PF_ADDR_BASE_EN
    assign base_s = base_addr;
`else
    assign base_s = {ADDR_W{1'b0}};
`endif

    assign illegal_s = cfg_illegal(win_k, op_type_in, 32'(img_w), 32'(img_h));

    pf_win_addr_gen #(
        .LIN_WIDTH (LIN_WIDTH),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .res      (res),
        .init     (init_s),
        .adv      (adv_s),
        .base     (base_s),
        .img_w    (img_w_r),
        .img_h    (img_h_r),
        .win_k    (win_k_r),
        .rd_addr  (rd_addr),
        .first_px (first_px_s),
        .last_rd  (last_rd_s)
    );

    // Next-state, address-generator control and issue-side start tag
    always_comb begin
        state_n     = state_r;
        flush_cnt_n = flush_cnt_r;
        init_s      = 1'b0;
        adv_s       = 1'b0;
        tag_s       = CYCLE;
        case (state_r)
            IDLE: begin
                if (start) state_n = LOAD;
                else       state_n = IDLE;
            end
            LOAD: begin
                init_s = 1'b1;
                if (illegal_s) state_n = DONE;
                else           state_n = SCAN;
            end
            SCAN: begin
                adv_s = 1'b1;
                tag_s = first_px_s;
                if (last_rd_s) begin
                    state_n     = FLUSH;
                    flush_cnt_n = 2'd0;
                end else begin
                    state_n = SCAN;
                end
            end
            FLUSH: begin
                // One extra tag pushes out the last window; stay until it reaches cntrl
                tag_s = (flush_cnt_r == 2'd0);
                if (flush_cnt_r == 2'd2) state_n = DONE;
                else                     flush_cnt_n = flush_cnt_r + 2'd1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, config latch, delay line and registered outputs
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r     <= IDLE;
            flush_cnt_r <= 2'd0;
            img_w_r     <= {LIN_WIDTH{1'b0}};
            img_h_r     <= {LIN_WIDTH{1'b0}};
            win_k_r     <= 3'd0;
            op_type_r   <= 2'b00;
            rd_en_r     <= 1'b0;
            din_valid_r <= 1'b0;
            tag_d1_r    <= 1'b0;
            cntrl_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            flush_cnt_r <= flush_cnt_n;
            if (state_r == LOAD) begin
                img_w_r   <= img_w;
                img_h_r   <= img_h;
                win_k_r   <= win_k;
                op_type_r <= op_type_in;
                cfg_err_r <= illegal_s;
            end
            rd_en_r     <= (state_n == SCAN);
            din_valid_r <= rd_en_r;
            tag_d1_r    <= tag_s;
            cntrl_r     <= tag_d1_r;
            busy_r      <= (state_n == LOAD) || (state_n == SCAN) || (state_n == FLUSH);
            done_r      <= (state_n == DONE);
        end
    end

    assign rd_en     = rd_en_r;
    assign din_valid = din_valid_r;
    assign cntrl     = cntrl_r;
    assign op_type   = op_type_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_pf_pool_sequencer.sv
// Table-driven bench for pf_pool_sequencer, with a frame memory (p[i]=i,
// 1-cycle latency) and a MIN/MAX compute-unit reference model on its outputs.
module tb_pf_pool_sequencer;
    import pf_pkg::*;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [1:0]  op_type_in;
    logic [9:0]  img_w, img_h;
    logic [2:0]  win_k;
`ifdef PF_ADDR_BASE_EN
    logic [19:0] base_addr = 20'd0;
`endif
    logic [19:0] rd_addr;
    logic        rd_en, din_valid, cntrl, busy, done, cfg_err;
    logic [1:0]  op_type;

    always #5 clk = ~clk;

    pf_pool_sequencer dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .op_type_in (op_type_in),
        .img_w      (img_w),
        .img_h      (img_h),
        .win_k      (win_k),
`ifdef PF_ADDR_BASE_EN
        .base_addr  (base_addr),
`endif
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .din_valid  (din_valid),
        .cntrl      (cntrl),
        .op_type    (op_type),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    // Memory + compute-unit reference: START_CYCLE emits the previous window
    logic [7:0] mem_q, d1_din, acc;
    logic       d1_v, valid_buf;
    int         res_val [256];
    int         res_cnt;

    always @(posedge clk or negedge res) begin
        if (!res) begin
            mem_q <= 8'd0; d1_din <= 8'd0; d1_v <= 1'b0;
            acc <= 8'd0; valid_buf <= 1'b0; res_cnt <= 0;
        end else begin
            mem_q  <= rd_en ? rd_addr[7:0] : 8'd0;
            d1_din <= mem_q;
            d1_v   <= din_valid;
            if (cntrl) begin
                if (valid_buf) begin
                    res_val[res_cnt % 256] <= int'(acc);
                    res_cnt <= res_cnt + 1;
                end
                acc       <= d1_din;
                valid_buf <= d1_v;
            end else if (d1_v) begin
                if (op_type == MAX) acc <= (d1_din > acc) ? d1_din : acc;
                else                acc <= (d1_din < acc) ? d1_din : acc;
            end
        end
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_addr"},   int'(rd_addr),   0);
        chk({tag, "_rd_en"},     int'(rd_en),     0);
        chk({tag, "_din_valid"}, int'(din_valid), 0);
        chk({tag, "_cntrl"},     int'(cntrl),     0);
        chk({tag, "_op_type"},   int'(op_type),   0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_cfg_err"},   int'(cfg_err),   0);
    endtask

    // Per-cycle observations of the last run; cycle 0 = start sampled
    int rd_cyc[$], rd_adr[$], cn_cyc[$], dn_cyc[$];
    int dv_n, busy1;

    task automatic run_frame(input int w, input int h, input int k, input int op,
                             input int s1, input int s2, input int s3, input int ncyc);
        rd_cyc.delete(); rd_adr.delete(); cn_cyc.delete(); dn_cyc.delete();
        dv_n = 0; busy1 = 0;
        img_w = 10'(w); img_h = 10'(h); win_k = 3'(k); op_type_in = 2'(op);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (rd_en) begin rd_cyc.push_back(c); rd_adr.push_back(int'(rd_addr)); end
            if (cntrl) cn_cyc.push_back(c);
            if (done) dn_cyc.push_back(c);
            if (din_valid) dv_n++;
            if (c == 1) busy1 = int'(busy);
            start = (c == 0) || (c == s1) || (c == s2) || (c == s3);
        end
        start = 1'b0;
    endtask

    typedef struct {
        int w, h, k, op, err, n_rd, done_c, n_cn, kk, a_off, n_res, r_off;
    } vec_t;
    vec_t tv [10];

    int exp_adr[$] = '{0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15,
                       0,1,5,6,2,3,7,8,
                       0,1,2,6,7,8,12,13,14,3,4,5,9,10,11,15,16,17,
                       0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15};
    int exp_res[$] = '{6,8, 0,2,8,10, 5,7,13,15, 0,3, 15};

    task automatic check_vec(input int v);
        int snap, d0;
        snap = res_cnt;
        run_frame(tv[v].w, tv[v].h, tv[v].k, tv[v].op, -1, -1, -1, tv[v].done_c + 3);
        d0 = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
        chk($sformatf("v%0d_done_cnt", v), dn_cyc.size(), 1);
        chk($sformatf("v%0d_done_cyc", v), d0, tv[v].done_c);
        chk($sformatf("v%0d_rd_cnt", v), rd_cyc.size(), tv[v].n_rd);
        for (int i = 0; i < rd_cyc.size() && i < tv[v].n_rd; i++) begin
            chk($sformatf("v%0d_rd_addr%0d", v, i), rd_adr[i], exp_adr[tv[v].a_off + i]);
            chk($sformatf("v%0d_rd_cyc%0d", v, i), rd_cyc[i], 2 + i);
        end
        chk($sformatf("v%0d_dv_cnt", v), dv_n, tv[v].n_rd);
        chk($sformatf("v%0d_cntrl_cnt", v), cn_cyc.size(), tv[v].n_cn);
        for (int i = 0; i < cn_cyc.size() && i < tv[v].n_cn; i++)
            chk($sformatf("v%0d_cntrl_cyc%0d", v, i), cn_cyc[i], 4 + i * tv[v].kk);
        chk($sformatf("v%0d_cfg_err", v), int'(cfg_err), tv[v].err);
        chk($sformatf("v%0d_op_type", v), int'(op_type), tv[v].op);
        chk($sformatf("v%0d_busy_c1", v), busy1, 1);
        chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
        if (tv[v].n_res > 0) begin
            chk($sformatf("v%0d_res_cnt", v), res_cnt - snap, tv[v].n_res);
            for (int i = 0; i < tv[v].n_res && snap + i < res_cnt; i++)
                chk($sformatf("v%0d_res%0d", v, i), res_val[(snap + i) % 256],
                    exp_res[tv[v].r_off + i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          w  h  k  op err n_rd done n_cn kk a_off n_res r_off
        tv[0] = '{4, 4, 2, 0, 0, 16, 21, 5,  4,  0, 0,  0};
        tv[1] = '{5, 3, 2, 2, 0,  8, 13, 3,  4, 16, 2,  0};
        tv[2] = '{4, 4, 5, 0, 1,  0,  2, 0,  4,  0, 0,  0};
        tv[3] = '{4, 4, 2, 3, 1,  0,  2, 0,  4,  0, 0,  0};
        tv[4] = '{4, 4, 1, 1, 1,  0,  2, 0,  1,  0, 0,  0};
        tv[5] = '{3, 4, 4, 1, 1,  0,  2, 0, 16,  0, 0,  0};
        tv[6] = '{4, 4, 2, 1, 0, 16, 21, 5,  4,  0, 4,  2};
        tv[7] = '{4, 4, 2, 2, 0, 16, 21, 5,  4,  0, 4,  6};
        tv[8] = '{6, 4, 3, 1, 0, 18, 23, 3,  9, 24, 2, 10};
        tv[9] = '{4, 4, 4, 2, 0, 16, 21, 2, 16, 42, 1, 12};

        res = 1'b0; start = 1'b0; op_type_in = 2'b00;
        img_w = 10'd4; img_h = 10'd4; win_k = 3'd2;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) check_vec(v);

        // start while busy (cycle 7) and in the done cycle (21) are ignored; 22 starts a new frame
        run_frame(4, 4, 2, 0, 7, 21, 22, 46);
        chk("seq_done_cnt", dn_cyc.size(), 2);
        chk("seq_done0", (dn_cyc.size() > 0) ? dn_cyc[0] : -1, 21);
        chk("seq_done1", (dn_cyc.size() > 1) ? dn_cyc[1] : -1, 43);
        chk("seq_rd_cnt", rd_cyc.size(), 32);
        for (int i = 0; i < 16 && i < rd_adr.size(); i++) begin
            chk($sformatf("seq_rd_addr%0d", i), rd_adr[i], exp_adr[i]);
            chk($sformatf("seq_rd_cyc%0d", i), rd_cyc[i], 2 + i);
        end
        chk("seq_second_first_rd", (rd_cyc.size() > 16) ? rd_cyc[16] : -1, 24);

        // reset asserted in cycle 10 of a frame aborts it at once
        img_w = 10'd4; img_h = 10'd4; win_k = 3'd2; op_type_in = 2'b01;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 10) begin
                chk("pre_rst_rd_en", int'(rd_en), 1);
                chk("pre_rst_busy", int'(busy), 1);
                res = 1'b0;
                #1;
                chk_all_zero("midrst");
            end
            start = (c == 0);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b1;
        begin
            int dn, rdn;
            dn = 0; rdn = 0;
            for (int c = 0; c < 25; c++) begin
                @(negedge clk);
                if (done) dn++;
                if (rd_en) rdn++;
            end
            chk("post_rst_no_done", dn, 0);
            chk("post_rst_no_rd", rdn, 0);
        end
        check_vec(0);
        check_vec(6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
